button_conditioner: RTL and testbench



---
 rtl/board_io_pkg.sv | 18 +
 rtl/debounce_bit.sv | 60 ++++++
 rtl/button_conditioner.sv | 69 ++++++
 tb/tb_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared Basys3 board I/O constants: button map, debounce lengths and
// the IO port addresses of the switch/button registers.
package board_io_pkg;

    localparam int unsigned BTN_N           = 5;
    localparam int unsigned BTN_INTR_IDX    = 4;
    localparam int unsigned BTN_RST_IDX     = 3;

    localparam int unsigned DB_CYCLES_SYNTH = 500000;
    localparam int unsigned DB_CYCLES_SIM   = 4;

    typedef enum logic [7:0] {
        IO_ADDR_SW_LO   = 8'h00,
        IO_ADDR_SW_HI   = 8'h01,
        IO_ADDR_BUTTONS = 8'h02
    } io_port_addr_e;

endpackage

// File: rtl/debounce_bit.sv
// One button bit: two-flop synchroniser, stability counter, debounced
// level and a registered one-cycle rising-edge pulse.
module debounce_bit
    import board_io_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_SYNTH
) (
    input  logic clk,
    input  logic s_reset,
    input  logic raw,
    output logic db,
    output logic rise
);

    localparam int unsigned   CW   = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          db_q;
    logic          db_d;
    logic          rise_q;
    logic          rise_d;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        // Any sample matching the current level restarts the count.
        if (sync2_q != db_q) begin
            if (cnt_q == TERM) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = db_d & ~db_q;
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
        end
    end

    assign db   = db_q;
    assign rise = rise_q;

endmodule

// File: rtl/button_conditioner.sv
// Basys3 push-button front end: per-button debounce, interrupt request
// with acknowledge handshake, and a stretched MCU reset.
module button_conditioner
    import board_io_pkg::*;
#(
    parameter int unsigned N_BTN       = BTN_N,
    parameter int unsigned DB_CYCLES   = DB_CYCLES_SYNTH,
    parameter int unsigned RST_STRETCH = 16,
    parameter int unsigned INTR_IDX    = BTN_INTR_IDX,
    parameter int unsigned RST_IDX     = BTN_RST_IDX
) (
    input  logic             clk,
    input  logic             s_reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise,
    output logic             intr_req,
    input  logic             intr_ack,
    output logic             rst_out
);

    localparam int unsigned   SW           = $clog2(RST_STRETCH + 1);
    localparam logic [SW-1:0] STRETCH_FULL = SW'(RST_STRETCH);
    localparam logic [SW-1:0] STRETCH_RISE = SW'(RST_STRETCH - 1);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk    (clk),
            .s_reset(s_reset),
            .raw    (btn_raw[i]),
            .db     (btn_db[i]),
            .rise   (btn_rise[i])
        );
    end

    logic          intr_q;
    logic          intr_d;
    logic [SW-1:0] stretch_q;
    logic [SW-1:0] stretch_d;

    // The rise pulse is ORed straight into both outputs so they react in the
    // same cycle as btn_rise; the registered state covers the cycles after it,
    // hence a rise reloads one less than a full stretch.
    always_comb begin
        intr_d    = btn_rise[INTR_IDX] | (intr_q & ~intr_ack);
        stretch_d = stretch_q;
        if (btn_rise[RST_IDX]) begin
            stretch_d = STRETCH_RISE;
        end else if (stretch_q != '0) begin
            stretch_d = stretch_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (s_reset) begin
            intr_q    <= 1'b0;
            stretch_q <= STRETCH_FULL;
        end else begin
            intr_q    <= intr_d;
            stretch_q <= stretch_d;
        end
    end

    assign intr_req = intr_q | btn_rise[INTR_IDX];
    assign rst_out  = (stretch_q != '0) | btn_rise[RST_IDX];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner against an event/timestamp model.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int RS = 3;
    localparam int II = 4;
    localparam int RI = 3;

    logic         clk = 1'b0;
    logic         s_reset = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_db;
    logic [N-1:0] btn_rise;
    logic         intr_req;
    logic         intr_ack = 1'b0;
    logic         rst_out;

    int n_chk  = 0;
    int n_pass = 0;

    button_conditioner #(
        .N_BTN(N), .DB_CYCLES(DB), .RST_STRETCH(RS), .INTR_IDX(II), .RST_IDX(RI)
    ) dut (
        .clk(clk), .s_reset(s_reset), .btn_raw(btn_raw), .btn_db(btn_db),
        .btn_rise(btn_rise), .intr_req(intr_req), .intr_ack(intr_ack), .rst_out(rst_out)
    );

    always #5 clk = ~clk;

    // Reference model: a level flips after DB consecutive edges in which the
    // synchronised sample (raw from two edges back) disagrees with it.
    // Interrupt and reset stretch are derived from edge timestamps.
    logic [N-1:0] m_db = '0, m_rise = '0, prev_eff = '0, prev2_eff = '0;
    bit           prev_rst = 1'b1;
    int           run [N];
    int           e_cnt = 0, last_rise_i = 0, last_ack = -100, last_trig = -100;
    bit           intr_valid = 1'b0;
    logic         m_intr = 1'b0, m_rst = 1'b1;

    always @(posedge clk) begin : model
        logic [N-1:0] sync_v;
        logic [N-1:0] cur_eff;
        sync_v  = prev_rst ? '0 : prev2_eff;
        cur_eff = s_reset ? '0 : btn_raw;
        m_rise  = '0;
        if (s_reset) begin
            m_db = '0;
            for (int i = 0; i < N; i++) run[i] = 0;
            intr_valid = 1'b0;
            last_trig  = e_cnt;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync_v[i] != m_db[i]) begin
                    run[i]++;
                    if (run[i] == DB) begin
                        m_db[i]   = sync_v[i];
                        m_rise[i] = sync_v[i];
                        run[i]    = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            if (m_rise[II]) begin
                intr_valid  = 1'b1;
                last_rise_i = e_cnt;
            end
            if (m_rise[RI]) last_trig = e_cnt;
            if (intr_ack) last_ack = e_cnt;
        end
        m_intr    = intr_valid && (last_ack <= last_rise_i + 1);
        m_rst     = (e_cnt - last_trig) < RS;
        prev2_eff = prev_eff;
        prev_eff  = cur_eff;
        prev_rst  = s_reset;
        e_cnt++;
    end

    task automatic test_reset();
        s_reset = 1'b1; btn_raw = '0; intr_ack = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_chk++; if (rst_out !== 1'b1) $display("FAIL reset_rst_out: got %b expected 1", rst_out); else n_pass++;
            n_chk++; if ({btn_db, btn_rise, intr_req} !== '0)
                $display("FAIL reset_outputs: got %h expected 0", {btn_db, btn_rise, intr_req}); else n_pass++;
        end
        s_reset = 1'b0;
        // k=0 is the cycle in which s_reset has just fallen
        for (int k = 0; k < 6; k++) begin
            n_chk++; if (rst_out !== (k < RS)) $display("FAIL reset_stretch[%0d]: got %b expected %b", k, rst_out, k < RS); else n_pass++;
            n_chk++; if ({btn_db, btn_rise, intr_req} !== '0)
                $display("FAIL reset_release_outputs: got %h expected 0", {btn_db, btn_rise, intr_req}); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_clean_press();
        btn_raw[0] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            n_chk++; if (btn_db[0] !== (n >= DB + 2)) $display("FAIL press_db edge %0d: got %b expected %b", n, btn_db[0], n >= DB + 2); else n_pass++;
            n_chk++; if (btn_rise[0] !== (n == DB + 2)) $display("FAIL press_rise edge %0d: got %b expected %b", n, btn_rise[0], n == DB + 2); else n_pass++;
        end
        btn_raw[0] = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            n_chk++; if (btn_db[0] !== (n < DB + 2)) $display("FAIL release_db edge %0d: got %b expected %b", n, btn_db[0], n < DB + 2); else n_pass++;
            n_chk++; if (btn_rise !== '0) $display("FAIL release_rise edge %0d: got %b expected 0", n, btn_rise); else n_pass++;
        end
    endtask

    task automatic test_bounce();
        for (int r = 0; r < 10; r++) begin
            for (int j = 0; j < 4; j++) begin
                btn_raw[1] = (j != 3);
                @(negedge clk);
                n_chk++; if ({btn_db[1], btn_rise[1]} !== 2'b00)
                    $display("FAIL bounce_reject: got db=%b rise=%b expected 0 0", btn_db[1], btn_rise[1]); else n_pass++;
            end
        end
        btn_raw[1] = 1'b1;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            n_chk++; if (btn_db[1] !== (n >= DB + 2)) $display("FAIL bounce_hold_db edge %0d: got %b expected %b", n, btn_db[1], n >= DB + 2); else n_pass++;
        end
        btn_raw[1] = 1'b0;
        repeat (8) begin
            @(negedge clk);
            n_chk++; if (btn_db !== m_db) $display("FAIL bounce_release_db: got %b expected %b", btn_db, m_db); else n_pass++;
        end
    endtask

    task automatic test_interrupt();
        bit found;
        btn_raw[II] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (btn_rise[II]) found = 1'b1;
        end
        n_chk++; if (!found) $display("FAIL intr_rise_timeout: got no pulse expected pulse"); else n_pass++;
        n_chk++; if (intr_req !== 1'b1) $display("FAIL intr_same_cycle: got %b expected 1", intr_req); else n_pass++;
        repeat (20) begin
            @(negedge clk);
            n_chk++; if (intr_req !== 1'b1 || m_intr !== 1'b1) $display("FAIL intr_hold: got %b expected 1 (model %b)", intr_req, m_intr); else n_pass++;
        end
        btn_raw[II] = 1'b0;
        repeat (8) @(negedge clk);
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
        n_chk++; if (intr_req !== 1'b0) $display("FAIL intr_ack_clear: got %b expected 0", intr_req); else n_pass++;
        // second press: ack is sampled on the same edge the pending rise lands
        btn_raw[II] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (btn_rise[II]) found = 1'b1;
        end
        n_chk++; if (!found) $display("FAIL intr_rise2_timeout: got no pulse expected pulse"); else n_pass++;
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
        repeat (3) begin
            n_chk++; if (intr_req !== 1'b1) $display("FAIL intr_rise_wins: got %b expected 1", intr_req); else n_pass++;
            @(negedge clk);
        end
        intr_ack = 1'b1;
        @(negedge clk);
        intr_ack = 1'b0;
        n_chk++; if (intr_req !== m_intr || m_intr !== 1'b0) $display("FAIL intr_ack_clear2: got %b expected 0", intr_req); else n_pass++;
        btn_raw[II] = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_button();
        bit found;
        for (int p = 0; p < 2; p++) begin
            btn_raw[RI] = 1'b1;
            found = 1'b0;
            for (int n = 0; n < 12 && !found; n++) begin
                @(negedge clk);
                if (btn_rise[RI]) found = 1'b1;
            end
            n_chk++; if (!found) $display("FAIL rstbtn_rise_timeout press %0d: got no pulse expected pulse", p); else n_pass++;
            for (int k = 0; k < 5; k++) begin
                n_chk++; if (rst_out !== (k < RS) || rst_out !== m_rst)
                    $display("FAIL rstbtn_stretch press %0d cycle %0d: got %b expected %b", p, k, rst_out, k < RS); else n_pass++;
                @(negedge clk);
            end
            btn_raw[RI] = 1'b0;
            repeat (7) @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        btn_raw[II] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (btn_rise[II]) found = 1'b1;
        end
        n_chk++; if (intr_req !== 1'b1) $display("FAIL mid_intr_pending: got %b expected 1", intr_req); else n_pass++;
        btn_raw[0] = 1'b1;
        repeat (4) @(negedge clk);
        s_reset = 1'b1;
        @(negedge clk);
        s_reset = 1'b0;
        n_chk++; if ({intr_req, btn_db, btn_rise, rst_out} !== {1'b0, {N{1'b0}}, {N{1'b0}}, 1'b1})
            $display("FAIL mid_abort: got req=%b db=%b rise=%b rst=%b expected 0 0 0 1", intr_req, btn_db, btn_rise, rst_out); else n_pass++;
        for (int n = 1; n <= 9; n++) begin
            @(negedge clk);
            n_chk++; if (btn_db[0] !== (n >= DB + 2)) $display("FAIL mid_redebounce edge %0d: got %b expected %b", n, btn_db[0], n >= DB + 2); else n_pass++;
            n_chk++; if ({btn_db, intr_req, rst_out} !== {m_db, m_intr, m_rst})
                $display("FAIL mid_model: got %b expected %b", {btn_db, intr_req, rst_out}, {m_db, m_intr, m_rst}); else n_pass++;
        end
        intr_ack = 1'b1;
        btn_raw = '0;
        @(negedge clk);
        intr_ack = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++)
                if ($urandom_range(11) == 0) btn_raw[i] = ~btn_raw[i];
            intr_ack = ($urandom_range(7) == 0);
            s_reset  = ($urandom_range(149) == 0);
            @(negedge clk);
            n_chk++; if (btn_db !== m_db) $display("FAIL rand_db cycle %0d: got %b expected %b", c, btn_db, m_db); else n_pass++;
            n_chk++; if (btn_rise !== m_rise) $display("FAIL rand_rise cycle %0d: got %b expected %b", c, btn_rise, m_rise); else n_pass++;
            n_chk++; if (intr_req !== m_intr) $display("FAIL rand_intr cycle %0d: got %b expected %b", c, intr_req, m_intr); else n_pass++;
            n_chk++; if (rst_out !== m_rst) $display("FAIL rand_rst cycle %0d: got %b expected %b", c, rst_out, m_rst); else n_pass++;
        end
        s_reset  = 1'b0;
        intr_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_interrupt();
        test_reset_button();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
